// File: rtl/cosh_job_dispatcher.sv
// Queues cosh arguments in a DEPTH-entry FIFO and runs them one at a time through the cosh datapath.
// Job latency is 4 cycles minimum; in_ready drops when the FIFO is full; the result is held until out_ready.
module cosh_job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_x,
    output logic        in_ready,
    output logic [15:0] cosh_x,
    output logic        cosh_start,
    input  logic        cosh_done,
    input  logic [17:0] cosh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_result,
    output logic [15:0] out_x,
    output logic [3:0]  fifo_count,
    output logic        busy,
    output logic        timeout_err
);

    localparam int PW = (DEPTH <= 2) ? 1 : (DEPTH <= 4) ? 2 : 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       mem_q [DEPTH];
    logic [15:0]       mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [3:0]        count_q, count_d;
    logic [15:0]       cosh_x_q, cosh_x_d;
    logic [5:0]        tmo_q, tmo_d;
    logic              out_valid_q, out_valid_d;
    logic [17:0]       out_result_q, out_result_d;
    logic [15:0]       out_x_q, out_x_d;
    logic              err_q, err_d;
    logic              push, pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_ready = (count_q < 4'(DEPTH));
        push     = in_valid && in_ready;
        pop      = (state_q == S_IDLE) && (count_q != 4'd0);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_x;
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        state_d      = state_q;
        cosh_x_d     = cosh_x_q;
        tmo_d        = tmo_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_x_d      = out_x_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cosh_x_d = mem_q[rd_ptr_q];
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmo_d   = 6'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final allowed cycle still wins over the timeout.
                if (cosh_done) begin
                    out_result_d = cosh_result;
                    out_x_d      = cosh_x_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    tmo_d = tmo_q + 6'd1;
                    if (tmo_q + 6'd1 == 6'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= 4'd0;
            cosh_x_q     <= 16'd0;
            tmo_q        <= 6'd0;
            out_valid_q  <= 1'b0;
            out_result_q <= 18'd0;
            out_x_q      <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cosh_x_q     <= cosh_x_d;
            tmo_q        <= tmo_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_x_q      <= out_x_d;
            err_q        <= err_d;
        end
    end

    assign cosh_x      = cosh_x_q;
    assign cosh_start  = (state_q == S_LAUNCH);
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_x       = out_x_q;
    assign fifo_count  = count_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_cosh_job_dispatcher.sv
// Directed and randomized checks of cosh_job_dispatcher against a queue-based job model.
module tb_cosh_job_dispatcher;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_x;
    logic        in_ready;
    logic [15:0] cosh_x;
    logic        cosh_start;
    logic        cosh_done;
    logic [17:0] cosh_result;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_result;
    logic [15:0] out_x;
    logic [3:0]  fifo_count;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    cosh_job_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready),
        .cosh_x(cosh_x), .cosh_start(cosh_start),
        .cosh_done(cosh_done), .cosh_result(cosh_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_x(out_x),
        .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_starts = 0;
    int          start_cyc = -1;
    logic [15:0] m_q[$];      // accepted, not yet launched, in push order
    logic [15:0] src_q[$];    // samples the upstream still wants to push
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    bit          started = 1'b0;
    logic [15:0] job_x = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: offer the head of src_q, then update the model from what the spec allows.
    task automatic tick();
        bit          acc;
        logic [15:0] px;
        in_valid = (src_q.size() > 0);
        px       = (src_q.size() > 0) ? src_q[0] : 16'h0;
        in_x     = px;
        chk("in_ready", 32'(in_ready), 32'(m_cnt < DEPTH));
        acc = in_valid && (m_cnt < DEPTH);
        @(posedge clk);
        #1;
        cyc++;
        if (cosh_start === 1'b1) begin
            n_starts++;
            chk("start_nonempty", 32'(m_q.size() > 0), 32'd1);
            if (m_q.size() > 0) begin
                chk("cosh_x", 32'(cosh_x), 32'(m_q[0]));
                job_x = m_q.pop_front();
                m_cnt--;
            end
            started   = 1'b1;
            start_cyc = cyc;
        end
        if (acc) begin
            m_q.push_back(px);
            void'(src_q.pop_front());
            m_cnt++;
        end
        chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; in_x = 16'hFFFF;
        cosh_done = 1'b1; cosh_result = 18'h3FFFF; out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0; in_valid = 1'b0; cosh_done = 1'b0; out_ready = 1'b0;
        m_q.delete(); src_q.delete(); m_cnt = 0; m_err = 1'b0; started = 1'b0;
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cosh_start", 32'(cosh_start), 32'd0);
        chk("rst_cosh_x", 32'(cosh_x), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_x", 32'(out_x), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    endtask

    // Leaves the bench sampling inside the LAUNCH cycle.
    task automatic wait_start();
        int n = 0;
        while (!started && n < 8) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(started), 32'd1);
        chk("start_now", 32'(start_cyc), 32'(cyc));
        started = 1'b0;
    endtask

    // Datapath answers in WAIT cycle k (k > TIMEOUT: never); downstream stalls for hold cycles.
    task automatic finish_job(input int k, input int hold, input logic [17:0] r);
        bit captured = 1'b0;
        cosh_done = 1'b1; cosh_result = ~r; out_ready = 1'b1;
        tick();
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_valid", 32'(out_valid), 32'd0);
        chk("launch_one_pulse", 32'(cosh_start), 32'd0);
        for (int w = 1; w <= TIMEOUT; w++) begin
            cosh_done   = (w == k);
            cosh_result = (w == k) ? r : 18'($urandom);
            out_ready   = 1'b0;
            if (w == TIMEOUT && k != w) m_err = 1'b1;
            tick();
            if (w == k) begin
                chk("cap_valid", 32'(out_valid), 32'd1);
                chk("cap_result", 32'(out_result), 32'(r));
                chk("cap_x", 32'(out_x), 32'(job_x));
                chk("cap_busy", 32'(busy), 32'd1);
                captured = 1'b1;
                break;
            end
            if (w == TIMEOUT) begin
                chk("tmo_valid", 32'(out_valid), 32'd0);
                chk("tmo_busy", 32'(busy), 32'd0);
            end else begin
                chk("wait_valid", 32'(out_valid), 32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
                chk("wait_no_start", 32'(cosh_start), 32'd0);
            end
        end
        cosh_done = 1'b0;
        if (captured) begin
            for (int i = 0; i < hold; i++) begin
                out_ready   = 1'b0;
                cosh_done   = 1'($urandom_range(0, 1));
                cosh_result = 18'($urandom);
                tick();
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_result", 32'(out_result), 32'(r));
                chk("hold_x", 32'(out_x), 32'(job_x));
                chk("hold_no_start", 32'(cosh_start), 32'd0);
            end
            cosh_done = 1'b0;
            out_ready = 1'b1;
            tick();
            chk("release_valid", 32'(out_valid), 32'd0);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        int          c0, s0, prev;
        logic [15:0] order [6];
        logic [15:0] tmp;
        in_valid = 1'b0; in_x = 16'd0; cosh_done = 1'b0; cosh_result = 18'd0; out_ready = 1'b0; rst = 1'b0;

        do_reset();

        // Single job, done six cycles after the start pulse.
        src_q.push_back(16'h8000);
        c0 = cyc; s0 = n_starts;
        wait_start();
        chk("first_start_latency", 32'(start_cyc - c0), 32'd2);
        chk("single_x", 32'(job_x), 32'h8000);
        finish_job(6, 0, 18'h0ABCD);
        tick();
        chk("single_one_start", 32'(n_starts - s0), 32'd1);
        chk("single_fifo_empty", 32'(fifo_count), 32'd0);

        // Fill past DEPTH; order preserved, full-FIFO push refused during a pop.
        order[0] = 16'h8000; order[1] = 16'hCCCC; order[2] = 16'h0000;
        order[3] = 16'h4000; order[4] = 16'hBB99; order[5] = 16'h1234;
        for (int i = 0; i < 6; i++) src_q.push_back(order[i]);
        wait_start();
        chk("order_0", 32'(job_x), 32'(order[0]));
        finish_job(1, 5, 18'($urandom));
        prev = -1;
        for (int i = 1; i < 6; i++) begin
            wait_start();
            if (i == 1) begin
                chk("full_pop_count", 32'(fifo_count), 32'd3);
                chk("full_push_refused", 32'(src_q.size()), 32'd1);
            end
            if (prev >= 0) chk("back_to_back_gap", 32'(start_cyc - prev), 32'd4);
            prev = start_cyc;
            chk($sformatf("order_%0d", i), 32'(job_x), 32'(order[i]));
            finish_job(1, 0, 18'($urandom));
        end

        // Long downstream stall.
        src_q.push_back(16'h2468);
        wait_start();
        finish_job(3, 10, 18'h15A5A);

        // Done on the last allowed cycle, then a real timeout, then the next entry.
        src_q.push_back(16'h1111); src_q.push_back(16'h2222); src_q.push_back(16'h3333);
        wait_start();
        finish_job(TIMEOUT, 0, 18'h2BEEF);
        chk("late_done_no_err", 32'(timeout_err), 32'd0);
        wait_start();
        finish_job(TIMEOUT + 1, 0, 18'd0);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        c0 = cyc;
        wait_start();
        chk("relaunch_after_timeout", 32'(start_cyc - c0), 32'd1);
        chk("relaunch_x", 32'(job_x), 32'h3333);
        finish_job(2, 1, 18'($urandom));
        chk("err_still_set", 32'(timeout_err), 32'd1);

        // Reset in WAIT with three entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) src_q.push_back(16'(16'hA000 + i));
        wait_start();
        cosh_done = 1'b0;
        tick();
        tick();
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cosh_done = 1'b1; cosh_result = 18'($urandom);
            tick();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_start", 32'(cosh_start), 32'd0);
        end
        cosh_done = 1'b0;

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            int n;
            n = $urandom_range(0, 3);
            if (m_cnt == 0 && src_q.size() == 0 && n == 0) n = 1;
            for (int j = 0; j < n; j++) begin
                tmp = 16'($urandom);
                src_q.push_back(tmp);
            end
            wait_start();
            finish_job($urandom_range(1, TIMEOUT + 2), $urandom_range(0, 3), 18'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
